// File: rtl/pc_fetch_sequencer.sv
// Next-PC selection and single-outstanding instruction fetch controller.
// Presents fetched words to decode with a valid/stall handshake.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misaligned_err,
  output logic [31:0] bad_addr
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_VALID
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        mis_q, mis_d;
  logic [31:0] bad_q, bad_d;

  logic        redir;
  logic        tgt_mis;
  logic [31:0] raw_tgt;
  logic [31:0] redir_pc;

  // Trap wins outright and its vector is trusted; jump beats branch.
  always_comb begin
    redir    = (state_q != S_BOOT) &&
               (trap_req || jump_valid || branch_taken);
    raw_tgt  = jump_valid ? jump_target : branch_target;
    tgt_mis  = !trap_req && (raw_tgt[1:0] != 2'b00);
    redir_pc = (trap_req || tgt_mis) ? TRAP_VECTOR : raw_tgt;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    mis_d   = 1'b0;
    bad_d   = bad_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          if (redir) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || redir) begin
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      S_VALID: begin
        if (!stall) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
    if (redir) begin
      pc_d    = redir_pc;
      valid_d = 1'b0;
      if (state_q == S_VALID) state_d = S_REQ;
      if (tgt_mis) begin
        mis_d = 1'b1;
        bad_d = raw_tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      mis_q   <= 1'b0;
      bad_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
    end
  end

  assign imem_req       = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign pc_out         = pc_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign misaligned_err = mis_q;
  assign bad_addr       = bad_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: vector table, memory responder model
// and a scoreboard of granted fetches.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        trap_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned_err;
  logic [31:0] bad_addr;

  pc_fetch_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_valid     (jump_valid),
    .jump_target    (jump_target),
    .trap_req       (trap_req),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misaligned_err (misaligned_err),
    .bad_addr       (bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic        stall;
    logic        gnt;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        tbl[10];
  int          errors = 0;
  int          checks = 0;
  int          lat    = 0;
  int          cnt    = 0;
  bit          pend   = 0;
  bit          use_bad = 0;
  logic [31:0] paddr  = 32'h0;
  logic        prev_valid = 1'b0;

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: memory responder, scoreboard push on grant, pop on valid.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    sb_t         e;
    g = imem_req && imem_gnt && reset_n;
    a = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (g) begin
      pend   = 1;
      cnt    = lat;
      paddr  = a;
      e.addr = a;
      e.data = memf(a);
      sb_q.push_back(e);
    end
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = use_bad ? BAD : memf(paddr);
        use_bad     = 0;
        pend        = 0;
      end else begin
        cnt--;
      end
    end
    if (instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got valid pc %h expected none",
                 instr_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr_pc", instr_pc, e.addr);
        chk("sb_instr", instr, e.data);
      end
    end
    prev_valid = instr_valid;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_pc"}, pc_out, 32'h0);
    chk({nm, "_req"}, {31'h0, imem_req}, 32'h0);
    chk({nm, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({nm, "_instr"}, instr, 32'h0);
    chk({nm, "_ipc"}, instr_pc, 32'h0);
    chk({nm, "_mis"}, {31'h0, misaligned_err}, 32'h0);
    chk({nm, "_bad"}, bad_addr, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h4};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h4};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h4};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h8};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hC};

    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump_valid    = 1'b0;
    jump_target   = 32'h0;
    trap_req      = 1'b0;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    tick();
    tick();
    chk_reset("rst");

    // Sequential fetch from reset, zero-wait memory.
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stall    = tbl[i].stall;
      imem_gnt = tbl[i].gnt;
      tick();
      chk($sformatf("seq%0d_req", i), {31'h0, imem_req},
          {31'h0, tbl[i].exp_req});
      chk($sformatf("seq%0d_valid", i), {31'h0, instr_valid},
          {31'h0, tbl[i].exp_valid});
      chk($sformatf("seq%0d_pc", i), pc_out, tbl[i].exp_pc);
    end

    // Stall hold at 0xC.
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_ipc", instr_pc, 32'hC);
      chk("stall_instr", instr, memf(32'hC));
      chk("stall_pc", pc_out, 32'hC);
      chk("stall_req", {31'h0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_req", {31'h0, imem_req}, 32'h1);
    chk("unstall_addr", imem_addr, 32'h10);
    chk("unstall_valid", {31'h0, instr_valid}, 32'h0);

    // Branch while waiting on a slow response: data must be dropped.
    lat = 2;
    tick();
    chk("kill_wait_req", {31'h0, imem_req}, 32'h0);
    use_bad       = 1;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    void'(sb_q.pop_front());
    chk("kill_pc", pc_out, 32'h40);
    chk("kill_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("kill_rv_pending", {31'h0, imem_rvalid}, 32'h1);
    tick();
    chk("kill_req2", {31'h0, imem_req}, 32'h1);
    chk("kill_addr", imem_addr, 32'h40);
    chk("kill_valid", {31'h0, instr_valid}, 32'h0);
    chk("kill_instr", instr, memf(32'hC));
    lat = 0;
    tick();
    tick();
    chk("kill_fetch_valid", {31'h0, instr_valid}, 32'h1);

    // Trap beats jump beats branch, and overrides stall.
    stall         = 1'b1;
    trap_req      = 1'b1;
    jump_valid    = 1'b1;
    jump_target   = 32'h80;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    trap_req     = 1'b0;
    jump_valid   = 1'b0;
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("prio_pc", pc_out, 32'h100);
    chk("prio_req", {31'h0, imem_req}, 32'h1);
    chk("prio_valid", {31'h0, instr_valid}, 32'h0);
    chk("prio_mis", {31'h0, misaligned_err}, 32'h0);
    tick();
    tick();

    // Misaligned jump target.
    jump_valid  = 1'b1;
    jump_target = 32'h42;
    tick();
    jump_valid = 1'b0;
    chk("mis_pulse", {31'h0, misaligned_err}, 32'h1);
    chk("mis_bad", bad_addr, 32'h42);
    chk("mis_pc", pc_out, 32'h100);
    chk("mis_req", {31'h0, imem_req}, 32'h1);
    tick();
    chk("mis_pulse_end", {31'h0, misaligned_err}, 32'h0);
    chk("mis_bad_hold", bad_addr, 32'h42);
    tick();

    // PC wrap at top of address space.
    stall       = 1'b1;
    jump_valid  = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick();
    jump_valid = 1'b0;
    stall      = 1'b0;
    chk("wrap_jpc", pc_out, 32'hFFFF_FFFC);
    tick();
    tick();
    tick();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);

    // Reset while waiting; the late response must be ignored.
    lat = 2;
    tick();
    chk("mid_wait_req", {31'h0, imem_req}, 32'h0);
    reset_n = 1'b0;
    tick();
    chk_reset("mid_rst");
    sb_q.delete();
    reset_n  = 1'b1;
    imem_gnt = 1'b0;
    lat      = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stray_valid", {31'h0, instr_valid}, 32'h0);
    end
    chk("stray_req", {31'h0, imem_req}, 32'h1);
    chk("stray_pc", pc_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
